// File: rtl/echo_request_deframer.sv
// echo_request_deframer
//   Parses framed messages from a 32-bit valid/ready link into tagged request
//   records {tag, meth, v} and queues them in a small FIFO. The FIFO head is
//   presented on the enq_ena/enq_rdy interface that feeds the request dispatcher.
//
//   Frame format: header beat [31:16] tag, [15:0] len, followed by len payload
//   beats. Payload beat 0 becomes meth and beat 1 becomes v. Any further beats
//   are consumed and dropped. Fields with no payload beat read as zero.
//
// Parameters
//   DEPTH    output FIFO entries (power of two, >= 2)
//   MAX_LEN  largest legal payload length. A longer header pulses err, and the
//            frame is still parsed.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   in_valid/in_data     link beat in
//   in_ready             link beat accepted when in_valid && in_ready
//   enq_ena              head record valid
//   enq_tag/meth/v       head record fields (zero while the FIFO is empty)
//   enq_rdy              consumer takes the head when enq_ena && enq_rdy
//   err                  one-cycle pulse on an over-length header
//
// Optional build macro ECHO_DEFRAMER_STATS_EN adds:
//   msg_count[15:0]      records written to the FIFO (wraps)
//   err_count[7:0]       err pulses (saturates at 255)

module echo_request_deframer #(
    parameter int DEPTH   = 2,
    parameter int MAX_LEN = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        enq_ena,
    output logic [15:0] enq_tag,
    output logic [31:0] enq_meth,
    output logic [31:0] enq_v,
    input  logic        enq_rdy,
    output logic        err
`ifdef ECHO_DEFRAMER_STATS_EN
    ,
    output logic [15:0] msg_count,
    output logic [7:0]  err_count
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    localparam logic [1:0] HDR  = 2'd0;
    localparam logic [1:0] PAY  = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;

    logic [1:0]  state, next_state;
    logic [15:0] cnt;
    logic [1:0]  idx;           // payload beat index, saturates at 2
    logic [15:0] tag_q;
    logic [31:0] meth_q, v_q;
    logic        err_q;
    logic        in_ready_q;

    logic [AW:0] wptr, rptr;
    logic [15:0] mem_tag  [DEPTH];
    logic [31:0] mem_meth [DEPTH];
    logic [31:0] mem_v    [DEPTH];

    logic        hdr_fire, pay_fire, last_beat;
    logic        full, empty, wr_en, rd_en;
    logic [31:0] rec_meth, rec_v;

    assign hdr_fire  = in_valid && in_ready_q && (state == HDR);
    assign pay_fire  = in_valid && in_ready_q && (state == PAY);
    assign last_beat = pay_fire && (cnt == 16'd1);

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    // The final payload beat may carry meth or v itself. The record is therefore
    // built from the live beat so that it can be written in the same cycle.
    assign rec_meth = (pay_fire && idx == 2'd0) ? in_data : meth_q;
    assign rec_v    = (pay_fire && idx == 2'd1) ? in_data : v_q;

    // full is taken before any same-cycle read, so a full FIFO never accepts a write.
    assign wr_en = (last_beat || state == PUSH) && !full;
    assign rd_en = !empty && enq_rdy;

    always_comb begin
        next_state = state;
        case (state)
            HDR:     if (hdr_fire) next_state = (in_data[15:0] == 16'd0) ? PUSH : PAY;
            PAY:     if (last_beat) next_state = full ? PUSH : HDR;
            PUSH:    if (!full) next_state = HDR;
            default: next_state = HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= HDR;
            cnt        <= '0;
            idx        <= '0;
            tag_q      <= '0;
            meth_q     <= '0;
            v_q        <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state      <= next_state;
            // in_ready is registered from the next state, so it reads 0 during reset.
            in_ready_q <= (next_state != PUSH);
            err_q      <= hdr_fire && (in_data[15:0] > MAX_LEN_W);
            if (hdr_fire) begin
                tag_q  <= in_data[31:16];
                cnt    <= in_data[15:0];
                idx    <= '0;
                meth_q <= '0;
                v_q    <= '0;
            end else if (pay_fire) begin
                cnt    <= cnt - 16'd1;
                meth_q <= rec_meth;
                v_q    <= rec_v;
                if (idx != 2'd2) idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_tag[wptr[AW-1:0]]  <= tag_q;
            mem_meth[wptr[AW-1:0]] <= rec_meth;
            mem_v[wptr[AW-1:0]]    <= rec_v;
        end
    end

    assign in_ready = in_ready_q;
    assign err      = err_q;
    assign enq_ena  = !empty;
    // Storage is not reset. The outputs are masked so that they read zero while the FIFO is empty.
    assign enq_tag  = empty ? '0 : mem_tag[rptr[AW-1:0]];
    assign enq_meth = empty ? '0 : mem_meth[rptr[AW-1:0]];
    assign enq_v    = empty ? '0 : mem_v[rptr[AW-1:0]];

`ifdef ECHO_DEFRAMER_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            msg_count <= '0;
            err_count <= '0;
        end else begin
            if (wr_en) msg_count <= msg_count + 16'd1;
            if (err_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_deframer.sv
// Testbench for echo_request_deframer. A table of frames is applied in order,
// followed by hand-written sequences for back-pressure, an over-length header,
// and a reset in the middle of a frame. A queue scoreboard holds the expected
// records, and the head of the FIFO is compared against it whenever the
// consumer takes a record.

module tb_echo_request_deframer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        enq_ena;
    logic [15:0] enq_tag;
    logic [31:0] enq_meth;
    logic [31:0] enq_v;
    logic        enq_rdy;
    logic        err;
`ifdef ECHO_DEFRAMER_STATS_EN
    logic [15:0] msg_count;
    logic [7:0]  err_count;
`endif

    echo_request_deframer #(.DEPTH(2), .MAX_LEN(255)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .enq_ena  (enq_ena),
        .enq_tag  (enq_tag),
        .enq_meth (enq_meth),
        .enq_v    (enq_v),
        .enq_rdy  (enq_rdy),
        .err      (err)
`ifdef ECHO_DEFRAMER_STATS_EN
        ,
        .msg_count(msg_count),
        .err_count(err_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] meth;
        logic [31:0] v;
    } rec_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [15:0] tag;
        logic [31:0] meth;
        logic [31:0] v;
        int          exp_err;
    } vec_t;

    rec_t sb[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;
    int   err_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Compare the head record against the scoreboard each time the consumer takes it.
    always @(negedge CLK) begin : monitor
        rec_t e;
        if (nRST && err) err_cycles++;
        if (nRST && enq_ena && enq_rdy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record: got tag %h, required none", enq_tag);
            end else begin
                e = sb.pop_front();
                chk("rec_tag",  {16'h0, enq_tag}, {16'h0, e.tag});
                chk("rec_meth", enq_meth, e.meth);
                chk("rec_v",    enq_v,    e.v);
            end
        end
    end

    // Beats are driven #1 after a rising edge. in_ready is registered, so it
    // is stable at that point for the edge that follows.
    task automatic send_beat(input logic [31:0] d);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(posedge CLK); #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept_timeout: got in_ready 0, required 1");
        end else begin
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] p0, input logic [31:0] p1);
        int unsigned len;
        len = hdr[15:0];
        send_beat(hdr);
        for (int unsigned i = 0; i < len; i++)
            send_beat(i == 0 ? p0 : (i == 1 ? p1 : i + 1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLK); #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        tbl[0] = '{32'h0001_0002, 32'h0000_ABCD, 32'h1234_5678, 16'h0001, 32'h0000_ABCD, 32'h1234_5678, 0};
        tbl[1] = '{32'h0007_0000, 32'h0,         32'h0,         16'h0007, 32'h0,         32'h0,         0};
        tbl[2] = '{32'h0001_0004, 32'h1,         32'h2,         16'h0001, 32'h1,         32'h2,         0};
        tbl[3] = '{32'h0003_0001, 32'hCAFE_F00D, 32'h0,         16'h0003, 32'hCAFE_F00D, 32'h0,         0};
        tbl[4] = '{32'hFFFF_00FF, 32'h55AA_55AA, 32'h0BAD_BEEF, 16'hFFFF, 32'h55AA_55AA, 32'h0BAD_BEEF, 0};
        tbl[5] = '{32'h1234_0003, 32'h1,         32'h2,         16'h1234, 32'h1,         32'h2,         0};

        nRST = 1'b0; in_valid = 1'b0; in_data = '0; enq_rdy = 1'b1;
        #2;
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_enq_ena",  {31'h0, enq_ena},  0);
        chk("rst_err",      {31'h0, err},      0);
        chk("rst_tag",      {16'h0, enq_tag},  0);
        chk("rst_meth",     enq_meth,          0);
        chk("rst_v",        enq_v,             0);
        #10 nRST = 1'b1;
        @(posedge CLK); #1;

        // Table frames with the consumer always ready
        for (int k = 0; k < 6; k++) begin
            e0 = err_cycles;
            sb.push_back('{tbl[k].tag, tbl[k].meth, tbl[k].v});
            send_frame(tbl[k].hdr, tbl[k].p0, tbl[k].p1);
            if (tbl[k].hdr[15:0] != 16'd0) begin
                chk("latency_ena", {31'h0, enq_ena}, 1);
            end else begin
                chk("push_ready_low", {31'h0, in_ready}, 0);
                @(posedge CLK); #1;
                chk("push_ready_back", {31'h0, in_ready}, 1);
                chk("push_ena", {31'h0, enq_ena}, 1);
            end
            wait_drain();
            chk("err_pulses", err_cycles - e0, tbl[k].exp_err);
        end

        // Consumer stalled: two records fill the FIFO and the third frame parks in PUSH
        enq_rdy = 1'b0;
        sb.push_back('{16'h0021, 32'hA1, 32'hB1});
        sb.push_back('{16'h0022, 32'hA2, 32'hB2});
        sb.push_back('{16'h0023, 32'hA3, 32'hB3});
        send_frame(32'h0021_0002, 32'hA1, 32'hB1);
        send_frame(32'h0022_0002, 32'hA2, 32'hB2);
        send_frame(32'h0023_0002, 32'hA3, 32'hB3);
        chk("bp_ready_low", {31'h0, in_ready}, 0);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("bp_hold_tag", {16'h0, enq_tag}, 32'h21);
        end
        chk("bp_still_parked", {31'h0, in_ready}, 0);
        chk("bp_ena", {31'h0, enq_ena}, 1);
        enq_rdy = 1'b1;
        wait_drain();
        @(posedge CLK); #1;
        chk("bp_ready_back", {31'h0, in_ready}, 1);

        // Over-length header: err pulses for one cycle and the frame is still consumed
        e0 = err_cycles;
        sb.push_back('{16'h0001, 32'h1111_1111, 32'h2222_2222});
        send_frame(32'h0001_1000, 32'h1111_1111, 32'h2222_2222);
        wait_drain();
        chk("overlen_err_pulses", err_cycles - e0, 1);
        chk("overlen_ready", {31'h0, in_ready}, 1);
`ifdef ECHO_DEFRAMER_STATS_EN
        chk("stat_err_count", {24'h0, err_count}, 1);
        chk("stat_msg_count", {16'h0, msg_count}, 10);
`endif

        // Reset in the middle of a frame, then parse a fresh frame
        send_beat(32'h0005_0003);
        send_beat(32'hDEAD_BEEF);
        send_beat(32'hBEEF_CAFE);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'h0, in_ready}, 0);
        chk("mid_rst_enq_ena",  {31'h0, enq_ena},  0);
        chk("mid_rst_err",      {31'h0, err},      0);
        chk("mid_rst_meth",     enq_meth,          0);
`ifdef ECHO_DEFRAMER_STATS_EN
        chk("mid_rst_msg_count", {16'h0, msg_count}, 0);
`endif
        #4 nRST = 1'b1;
        @(posedge CLK); #1;
        sb.push_back('{16'h0009, 32'h42, 32'h0});
        send_beat(32'h0009_0001);
        repeat (4) @(posedge CLK);
        #1;
        chk("gap_ready_held", {31'h0, in_ready}, 1);
        chk("gap_no_record",  {31'h0, enq_ena},  0);
        send_beat(32'h0000_0042);
        chk("fresh_latency_ena", {31'h0, enq_ena}, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
